// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline stall/bubble control slice.
//
// Contents:
//   REG_W, TNEW_W, TUSE_W      field widths for register addresses and Tnew/Tuse
//   TUSE_NONE                  Tuse encoding for an operand the D instr does not read
//   MULT_CYCLES_DEF/DIV_..DEF  default busy lengths of the mult/div unit
//   md_state_t                 mult/div sequencer state
//   raw_hit()                  one RAW comparison of a D source against a producer
package cpu_pkg;

    localparam int REG_W  = 5;
    localparam int TNEW_W = 3;
    localparam int TUSE_W = 2;

    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // A producer blocks the D instruction when it writes the register being
    // read and its result will not exist by the time the operand is needed.
    // Tuse is zero-extended so the comparison is unsigned 3-bit.
    function automatic logic raw_hit(
        input logic [REG_W-1:0]  src,
        input logic [TUSE_W-1:0] tuse,
        input logic [REG_W-1:0]  dst,
        input logic [TNEW_W-1:0] tnew
    );
        return (src == dst) && (tnew > {1'b0, tuse});
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Multi-cycle mult/div sequencer.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   md_start   in   mult/div in E this cycle; honoured only from IDLE
//   md_is_div  in   1 = div/divu (DIV_CYCLES), 0 = mult/multu (MULT_CYCLES)
//   md_busy    out  unit occupied (state == BUSY)
//   md_done    out  last busy cycle; HI/LO valid next cycle
//
// The unit is busy for exactly N cycles after the start cycle; the counter
// is loaded with N-1 and the final busy cycle is the one where it reads 0.
module md_seq
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy,
    output logic md_done
);

    // Refuse to elaborate with a length the countdown cannot represent.
    if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_len
        $error("md_seq: MULT_CYCLES and DIV_CYCLES must be >= 1");
    end
    if ((MULT_CYCLES - 1) >= (2 ** CNT_W) || (DIV_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_cnt
        $error("md_seq: CNT_W too narrow for MULT_CYCLES-1 / DIV_CYCLES-1");
    end

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values; blocking here would let cnt
    // see the new state within the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        state <= BUSY;
                        cnt   <= md_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    // A start seen here (including the done cycle) is dropped.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign md_busy = (state == BUSY);
    assign md_done = (state == BUSY) && (cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble controller for the 5-stage F/D/E/M/W pipeline.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   rs_D, rt_D              D-stage source register addresses
//   tuse_rs_D, tuse_rt_D    cycles until D needs the operand (3 = unused)
//   md_use_D                D instr touches the mult/div unit or HI/LO
//   dst_E, tnew_E           E-stage destination (0 = none) and cycles to result
//   dst_M, tnew_M           M-stage destination (0 = none) and cycles to result
//   md_start_E, md_is_div_E start the mult/div unit from E, and which op
//   pc_en, fd_en            PC and F/D register enables (low = hold)
//   de_clr                  load a NOP bubble into D/E
//   md_busy, md_done        mult/div unit status
//   stall_cnt               saturating count of stalled cycles
//
// Stall decisions are purely combinational; only the mult/div sequencer and
// the performance counter hold state.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs_D,
    input  logic [REG_W-1:0]  rt_D,
    input  logic [TUSE_W-1:0] tuse_rs_D,
    input  logic [TUSE_W-1:0] tuse_rt_D,
    input  logic              md_use_D,
    input  logic [REG_W-1:0]  dst_E,
    input  logic [TNEW_W-1:0] tnew_E,
    input  logic [REG_W-1:0]  dst_M,
    input  logic [TNEW_W-1:0] tnew_M,
    input  logic              md_start_E,
    input  logic              md_is_div_E,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_clr,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cnt
);

    logic haz_rs;
    logic haz_rt;
    logic haz_md;
    logic stall;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_seq (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start_E),
        .md_is_div (md_is_div_E),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    // $0 is never a real dependency, so a zero source cannot match a
    // "no destination" encoding of 0 in E or M.
    assign haz_rs = (rs_D != '0) &&
                    (raw_hit(rs_D, tuse_rs_D, dst_E, tnew_E) ||
                     raw_hit(rs_D, tuse_rs_D, dst_M, tnew_M));
    assign haz_rt = (rt_D != '0) &&
                    (raw_hit(rt_D, tuse_rt_D, dst_E, tnew_E) ||
                     raw_hit(rt_D, tuse_rt_D, dst_M, tnew_M));

    // md_start_E counts as busy so a D instr cannot slip past a mult/div
    // that is entering the unit in the same cycle.
    assign haz_md = md_use_D && (md_busy || md_start_E);

    assign stall  = haz_rs || haz_rt || haz_md;
    assign pc_en  = !stall;
    assign fd_en  = !stall;
    assign de_clr = stall;

    // NOTE: the counter is cleared by the asynchronous reset so it reads 0
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. A second instance with a 4-bit
// performance counter shares the inputs to exercise saturation.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, dst_E, dst_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D;
    logic [2:0]  tnew_E, tnew_M;
    logic        md_use_D, md_start_E, md_is_div_E;

    logic        pc_en, fd_en, de_clr, md_busy, md_done;
    logic [31:0] stall_cnt;
    logic        pc_en_s, fd_en_s, de_clr_s, md_busy_s, md_done_s;
    logic [3:0]  stall_cnt_s;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .md_use_D(md_use_D), .dst_E(dst_E), .tnew_E(tnew_E), .dst_M(dst_M), .tnew_M(tnew_M),
        .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
        .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4), .PERF_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .md_use_D(md_use_D), .dst_E(dst_E), .tnew_E(tnew_E), .dst_M(dst_M), .tnew_M(tnew_M),
        .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
        .pc_en(pc_en_s), .fd_en(fd_en_s), .de_clr(de_clr_s),
        .md_busy(md_busy_s), .md_done(md_done_s), .stall_cnt(stall_cnt_s)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; dst_E = 0; dst_M = 0;
        tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 0; tnew_M = 0;
        md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
    endtask

    task automatic check_stall(input string name, input logic exp_stall);
        checks++;
        if ({pc_en, fd_en, de_clr} !== {~exp_stall, ~exp_stall, exp_stall}) begin
            errors++;
            $display("FAIL %s: pc_en/fd_en/de_clr=%b%b%b expected %b%b%b", name,
                     pc_en, fd_en, de_clr, ~exp_stall, ~exp_stall, exp_stall);
        end
    endtask

    task automatic check_cnt(input string name);
        logic [3:0] exp_s;
        exp_s = (exp_cnt > 15) ? 4'hF : 4'(exp_cnt);
        checks++;
        if (stall_cnt !== 32'(exp_cnt) || stall_cnt_s !== exp_s) begin
            errors++;
            $display("FAIL %s: stall_cnt=%0d/%0d expected %0d/%0d", name,
                     stall_cnt, stall_cnt_s, exp_cnt, exp_s);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #12;
        checks++;
        if ({pc_en, fd_en, de_clr, md_busy, md_done} !== 5'b11000 || stall_cnt !== 0 || stall_cnt_s !== 0) begin
            errors++;
            $display("FAIL reset_state: pc/fd/clr/busy/done=%b%b%b%b%b cnt=%0d expected 11000 cnt=0",
                     pc_en, fd_en, de_clr, md_busy, md_done, stall_cnt);
        end
        tick();
        reset = 1'b1;
        tick();
        exp_cnt = 0;
        check_cnt("reset_cnt_after_release");
    endtask

    task automatic test_load_use();
        clear_inputs();
        rs_D = 5; tuse_rs_D = 0; dst_E = 5; tnew_E = 2;
        #1 check_stall("load_use_rs", 1'b1);
        tick(); exp_cnt++;
        check_cnt("load_use_cnt");
        clear_inputs();
        rt_D = 7; tuse_rt_D = 1; dst_M = 7; tnew_M = 2;
        #1 check_stall("raw_rt_M", 1'b1);
        tick(); exp_cnt++;
        check_cnt("raw_rt_M_cnt");
        clear_inputs();
        rs_D = 9; tuse_rs_D = 1; dst_E = 9; tnew_E = 1;
        #1 check_stall("tnew_eq_tuse", 1'b0);
        tick();
        check_cnt("tnew_eq_tuse_cnt");
    endtask

    task automatic test_forward();
        clear_inputs();
        rs_D = 5; tuse_rs_D = 1; dst_M = 5; tnew_M = 1;
        #1 check_stall("forward_M", 1'b0);
        tick();
        clear_inputs();
        rs_D = 0; tuse_rs_D = 0; dst_E = 0; tnew_E = 3;
        #1 check_stall("zero_reg", 1'b0);
        tick();
        clear_inputs();
        rs_D = 5; tuse_rs_D = 2'd3; dst_E = 5; tnew_E = 3;
        #1 check_stall("tuse_none", 1'b0);
        tick();
        check_cnt("forward_cnt");
    endtask

    task automatic test_mult();
        clear_inputs();
        md_use_D = 1; md_start_E = 1; md_is_div_E = 0;
        #1 check_stall("mult_c0_stall", 1'b1);
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_c0_busy: md_busy=%b expected 0", md_busy);
        end
        tick(); exp_cnt++;
        md_start_E = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (md_busy !== 1'b1 || md_done !== (c == 5) || de_clr !== 1'b1) begin
                errors++;
                $display("FAIL mult_c%0d: busy=%b done=%b de_clr=%b expected 1 %b 1",
                         c, md_busy, md_done, de_clr, (c == 5));
            end
            tick(); exp_cnt++;
        end
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || de_clr !== 1'b0) begin
            errors++;
            $display("FAIL mult_c6_idle: busy=%b done=%b de_clr=%b expected 0 0 0",
                     md_busy, md_done, de_clr);
        end
        check_cnt("mult_cnt");
        tick();
    endtask

    task automatic test_div();
        clear_inputs();
        md_start_E = 1; md_is_div_E = 1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            // Starts mid-BUSY and in the done cycle must both be dropped.
            md_start_E  = (c == 4) || (c == 10);
            md_is_div_E = (c == 10);
            #1;
            checks++;
            if (md_busy !== 1'b1 || md_done !== (c == 10)) begin
                errors++;
                $display("FAIL div_c%0d: busy=%b done=%b expected 1 %b",
                         c, md_busy, md_done, (c == 10));
            end
            tick();
        end
        md_start_E = 0;
        for (int c = 11; c <= 12; c++) begin
            #1;
            checks++;
            if (md_busy !== 1'b0 || md_done !== 1'b0) begin
                errors++;
                $display("FAIL div_c%0d_idle: busy=%b done=%b expected 0 0", c, md_busy, md_done);
            end
            tick();
        end
        check_cnt("div_cnt");
    endtask

    task automatic test_async_reset();
        clear_inputs();
        md_start_E = 1; md_is_div_E = 1;
        tick();
        md_start_E = 0;
        tick();
        tick();
        #3 reset = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || stall_cnt !== 0 || stall_cnt_s !== 0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b cnt=%0d expected 0 0 0",
                     md_busy, md_done, stall_cnt);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (md_busy !== 1'b0 || md_done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_c%0d: busy=%b done=%b expected 0 0", c, md_busy, md_done);
            end
            tick();
        end
        check_cnt("post_reset_cnt");
    endtask

    task automatic test_simultaneous();
        int waited;
        clear_inputs();
        rs_D = 5; tuse_rs_D = 0; dst_E = 5; tnew_E = 2;
        md_use_D = 1; md_start_E = 1; md_is_div_E = 0;
        #1 check_stall("raw_and_md", 1'b1);
        tick(); exp_cnt++;
        check_cnt("raw_and_md_single_inc");
        clear_inputs();
        waited = 0;
        while (md_busy === 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: md_busy=%b after %0d cycles expected 0", md_busy, waited);
        end
        check_cnt("simul_drain_cnt");
    endtask

    task automatic test_saturation();
        clear_inputs();
        rt_D = 3; tuse_rt_D = 0; dst_M = 3; tnew_M = 1;
        for (int c = 0; c < 20; c++) begin
            tick(); exp_cnt++;
            check_cnt($sformatf("sat_c%0d", c));
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_mult();
        test_div();
        test_async_reset();
        test_simultaneous();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
